// File: rtl/stream_mux_rr.sv
// stream_mux_rr: registered N-to-1 valid/ready stream multiplexer with round-robin arbitration.
// Define MUX_PKT_LOCK_EN to hold the grant on one channel until its packet's inLast beat.
module stream_mux_rr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CH_W     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       selMask,
    input  logic [CHANNELS-1:0]       inValid,
    input  logic [CHANNELS-1:0]       inLast,
    input  logic [CHANNELS*WIDTH-1:0] dataInBus,
    output logic [CHANNELS-1:0]       inReady,
    output logic [WIDTH-1:0]          dataOut,
    output logic                      outValid,
    output logic                      outLast,
    output logic [CH_W-1:0]           outChannel,
    input  logic                      outReady,
    output logic [CHANNELS-1:0]       grantOneHot
);

    logic [WIDTH-1:0]    ch_data [CHANNELS];

    logic [WIDTH-1:0]    data_q, data_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic [CH_W-1:0]     chan_q, chan_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;

    logic [CHANNELS-1:0] eligible;
    logic [CHANNELS-1:0] above_ptr;
    logic [CHANNELS-1:0] search_vec;
    logic [CHANNELS-1:0] grant;
    logic [CH_W-1:0]     grant_idx;
    logic                grant_any;
    logic                load;
    logic                xfer;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
            assign ch_data[gi] = dataInBus[gi*WIDTH +: WIDTH];
        end
    endgenerate

`ifdef MUX_PKT_LOCK_EN
    logic            lock_q, lock_d;
    logic [CH_W-1:0] lock_ch_q, lock_ch_d;

    // While a packet is open only its owner may continue, regardless of selMask.
    always_comb begin
        eligible = inValid & selMask;
        if (lock_q) begin
            eligible            = '0;
            eligible[lock_ch_q] = inValid[lock_ch_q];
        end
    end
`else
    assign eligible = inValid & selMask;
`endif

    // Round-robin: prefer the lowest eligible channel above ptr, otherwise wrap to the lowest overall.
    always_comb begin
        above_ptr = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            above_ptr[i] = (i > int'(ptr_q));
        end
        search_vec = ((eligible & above_ptr) != '0) ? (eligible & above_ptr) : eligible;
    end

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = |search_vec;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (search_vec[i]) begin
                grant_idx = CH_W'(i);
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign load        = ~valid_q | outReady;
    assign xfer        = load & grant_any;
    assign inReady     = {CHANNELS{load}} & grant;
    assign grantOneHot = grant;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        chan_d  = chan_q;
        ptr_d   = ptr_q;
`ifdef MUX_PKT_LOCK_EN
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
`endif
        if (xfer) begin
            data_d  = ch_data[grant_idx];
            last_d  = inLast[grant_idx];
            chan_d  = grant_idx;
            valid_d = 1'b1;
`ifdef MUX_PKT_LOCK_EN
            // ptr only advances when a packet closes; mid-packet beats keep the lock instead.
            if (inLast[grant_idx]) begin
                lock_d = 1'b0;
                ptr_d  = grant_idx;
            end else begin
                lock_d    = 1'b1;
                lock_ch_d = grant_idx;
            end
`else
            ptr_d = grant_idx;
`endif
        end else if (outReady) begin
            // Drained with nothing to refill: payload registers keep their stale contents.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            chan_q  <= '0;
            ptr_q   <= CH_W'(CHANNELS - 1);
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            chan_q  <= chan_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef MUX_PKT_LOCK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
        end
    end
`endif

    assign dataOut    = data_q;
    assign outValid   = valid_q;
    assign outLast    = last_q;
    assign outChannel = chan_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed scenarios plus randomized traffic against a reference model.
// Build with MUX_PKT_LOCK_EN defined to exercise the packet-lock variant.
module tb_stream_mux_rr;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   selMask;
    logic [N-1:0]   inValid;
    logic [N-1:0]   inLast;
    logic [N*W-1:0] dataInBus;
    logic [N-1:0]   inReady;
    logic [W-1:0]   dataOut;
    logic           outValid;
    logic           outLast;
    logic [1:0]     outChannel;
    logic           outReady;
    logic [N-1:0]   grantOneHot;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int         m_ptr;
    bit         m_valid;
    logic [W-1:0] m_data;
    bit         m_last;
    int         m_chan;
    bit         m_locked;
    int         m_lock_ch;

    stream_mux_rr #(.WIDTH(W), .CHANNELS(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .selMask    (selMask),
        .inValid    (inValid),
        .inLast     (inLast),
        .dataInBus  (dataInBus),
        .inReady    (inReady),
        .dataOut    (dataOut),
        .outValid   (outValid),
        .outLast    (outLast),
        .outChannel (outChannel),
        .outReady   (outReady),
        .grantOneHot(grantOneHot)
    );

    always #5 clk = ~clk;

    function automatic int model_grant();
        int c;
        if (m_locked) return inValid[m_lock_ch] ? m_lock_ch : -1;
        for (int off = 1; off <= N; off++) begin
            c = (m_ptr + off) % N;
            if (inValid[c] && selMask[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = N - 1; m_valid = 0; m_data = '0; m_last = 0; m_chan = 0;
        m_locked = 0; m_lock_ch = 0;
    endtask

    task automatic model_step();
        int g;
        bit ld;
        ld = !m_valid || outReady;
        g  = model_grant();
        if (ld && g >= 0) begin
            m_data  = dataInBus[g*W +: W];
            m_last  = inLast[g];
            m_chan  = g;
            m_valid = 1;
`ifdef MUX_PKT_LOCK_EN
            if (inLast[g]) begin m_locked = 0; m_ptr = g; end
            else begin m_locked = 1; m_lock_ch = g; end
`else
            m_ptr = g;
`endif
        end else if (outReady) begin
            m_valid = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; inValid = '0; inLast = '0; selMask = '0; dataInBus = '0; outReady = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        selMask = 4'hF; inValid = 4'b0001; inLast = 4'b0001; outReady = 1'b0;
        dataInBus[0 +: W] = 8'h3C;
        #1;
        tick();
        total++; if (outValid !== 1'b1) begin bad++; $display("FAIL reset_prefill outValid got=%b want=1", outValid); end
        #2 reset = 1'b1;
        #1;
        total++; if (outValid !== 1'b0) begin bad++; $display("FAIL reset_async outValid got=%b want=0", outValid); end
        total++; if (dataOut !== 8'h00) begin bad++; $display("FAIL reset_async dataOut got=%h want=00", dataOut); end
        total++; if (outLast !== 1'b0) begin bad++; $display("FAIL reset_async outLast got=%b want=0", outLast); end
        total++; if (outChannel !== 2'd0) begin bad++; $display("FAIL reset_async outChannel got=%0d want=0", outChannel); end
        inValid = '0;
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        total++; if (inReady !== 4'b0000) begin bad++; $display("FAIL reset_idle inReady got=%b want=0000", inReady); end
        total++; if (grantOneHot !== 4'b0000) begin bad++; $display("FAIL reset_idle grant got=%b want=0000", grantOneHot); end
        tick();
        total++; if (outValid !== 1'b0) begin bad++; $display("FAIL reset_idle outValid got=%b want=0", outValid); end
        $display("test_reset complete");
    endtask

    task automatic test_round_robin();
        logic [N-1:0] want;
        do_reset();
        selMask = 4'hF; inValid = 4'hF; inLast = 4'hF; outReady = 1'b1;
        for (int i = 0; i < N; i++) dataInBus[i*W +: W] = 8'hA0 + 8'(i);
        #1;
        for (int k = 0; k < 8; k++) begin
            want = '0; want[k % N] = 1'b1;
            total++; if (inReady !== want) begin bad++; $display("FAIL rr_ready[%0d] got=%b want=%b", k, inReady, want); end
            tick();
            total++; if (dataOut !== 8'hA0 + 8'(k % N) || outValid !== 1'b1) begin
                bad++; $display("FAIL rr_data[%0d] got=%h/%b want=%h/1", k, dataOut, outValid, 8'hA0 + 8'(k % N));
            end
            $display("rr beat %0d data=%h ch=%0d", k, dataOut, outChannel);
        end
    endtask

    task automatic test_mask();
        logic [N-1:0] want;
        do_reset();
        selMask = 4'b0101; inValid = 4'hF; inLast = 4'hF; outReady = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            want = (k % 2 == 1) ? 4'b0100 : 4'b0001;
            total++; if (inReady !== want) begin bad++; $display("FAIL mask_ready[%0d] got=%b want=%b", k, inReady, want); end
            tick();
            total++; if (outChannel !== ((k % 2 == 1) ? 2'd2 : 2'd0)) begin
                bad++; $display("FAIL mask_chan[%0d] got=%0d want=%0d", k, outChannel, (k % 2 == 1) ? 2 : 0);
            end
            $display("mask beat %0d ch=%0d", k, outChannel);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        selMask = 4'hF; inValid = 4'b0001; inLast = 4'hF; outReady = 1'b1;
        dataInBus = {8'h99, 8'h88, 8'h77, 8'h55};
        #1;
        tick();
        total++; if (dataOut !== 8'h55 || outValid !== 1'b1) begin bad++; $display("FAIL bp_load got=%h/%b want=55/1", dataOut, outValid); end
        outReady = 1'b0; inValid = 4'hF; dataInBus[0 +: W] = 8'h66;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (inReady !== 4'b0000) begin bad++; $display("FAIL bp_ready[%0d] got=%b want=0000", k, inReady); end
            tick();
            total++; if (dataOut !== 8'h55 || outValid !== 1'b1) begin bad++; $display("FAIL bp_hold[%0d] got=%h/%b want=55/1", k, dataOut, outValid); end
        end
        outReady = 1'b1;
        #1;
        total++; if (inReady !== 4'b0010) begin bad++; $display("FAIL bp_release_ready got=%b want=0010", inReady); end
        tick();
        total++; if (dataOut !== 8'h77 || outValid !== 1'b1) begin bad++; $display("FAIL bp_refill got=%h/%b want=77/1", dataOut, outValid); end
        $display("backpressure refill data=%h", dataOut);
    endtask

    task automatic test_packet_lock();
        int exp_ch[5];
        int n;
        int beat;
        bit acc;
`ifdef MUX_PKT_LOCK_EN
        exp_ch = '{1, 1, 1, 2, 0}; n = 4;
`else
        exp_ch = '{1, 2, 1, 2, 1}; n = 5;
`endif
        do_reset();
        selMask = 4'hF; outReady = 1'b1; beat = 0;
        inValid = 4'b0100; inLast = 4'b0100; dataInBus[2*W +: W] = 8'h22;
        for (int k = 0; k < n; k++) begin
            inValid[1] = (beat < 3);
            inLast[1]  = (beat == 2);
            dataInBus[1*W +: W] = 8'h10 + 8'(beat);
            #1;
            acc = inReady[1];
            tick();
            if (acc) beat++;
            total++; if (outChannel !== 2'(exp_ch[k])) begin bad++; $display("FAIL lock_chan[%0d] got=%0d want=%0d", k, outChannel, exp_ch[k]); end
            $display("lock beat %0d ch=%0d data=%h last=%b", k, outChannel, dataOut, outLast);
        end
    endtask

    task automatic test_drain();
        do_reset();
        selMask = 4'hF; inLast = 4'hF; outReady = 1'b1;
        dataInBus = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        inValid = 4'b0010;
        #1;
        tick();
        inValid = 4'b1000;
        #1;
        total++; if (inReady !== 4'b1000) begin bad++; $display("FAIL drain_ready got=%b want=1000", inReady); end
        tick();
        total++; if (outValid !== 1'b1 || outChannel !== 2'd3) begin bad++; $display("FAIL drain_load got=%b/%0d want=1/3", outValid, outChannel); end
        inValid = 4'b0000;
        #1;
        tick();
        total++; if (outValid !== 1'b0) begin bad++; $display("FAIL drain_empty outValid got=%b want=0", outValid); end
        total++; if (outChannel !== 2'd3 || dataOut !== 8'hD3) begin bad++; $display("FAIL drain_stale got=%0d/%h want=3/d3", outChannel, dataOut); end
        inValid = 4'hF;
        #1;
        total++; if (grantOneHot !== 4'b0001) begin bad++; $display("FAIL drain_next_grant got=%b want=0001", grantOneHot); end
        $display("drain next grant=%b", grantOneHot);
    endtask

    task automatic test_random();
        int g;
        logic [N-1:0] eg;
        logic [N-1:0] er;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            inValid  = 4'($urandom);
            selMask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            inLast   = 4'($urandom);
            dataInBus = 32'($urandom);
            outReady = ($urandom_range(0, 3) != 0);
            #1;
            g  = model_grant();
            eg = '0;
            if (g >= 0) eg[g] = 1'b1;
            er = (!m_valid || outReady) ? eg : 4'b0000;
            total++; if (grantOneHot !== eg) begin bad++; $display("FAIL rand_grant[%0d] got=%b want=%b", k, grantOneHot, eg); end
            total++; if (inReady !== er) begin bad++; $display("FAIL rand_ready[%0d] got=%b want=%b", k, inReady, er); end
            if (er != 0) $display("rand xfer %0d ch=%0d data=%h last=%b", k, g, dataInBus[g*W +: W], inLast[g]);
            tick();
            total++; if (outValid !== m_valid) begin bad++; $display("FAIL rand_valid[%0d] got=%b want=%b", k, outValid, m_valid); end
            if (m_valid) begin
                total++; if (dataOut !== m_data || outChannel !== 2'(m_chan) || outLast !== m_last) begin
                    bad++; $display("FAIL rand_out[%0d] got=%h/%0d/%b want=%h/%0d/%b", k, dataOut, outChannel, outLast, m_data, m_chan, m_last);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; inValid = '0; inLast = '0; selMask = '0; dataInBus = '0; outReady = 1'b0;
        model_reset();
        test_reset();
        test_round_robin();
        test_mask();
        test_backpressure();
        test_packet_lock();
        test_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
